fec32_ctrl: RTL



---
 rtl/fec32_pkg.sv | 31 +++
 rtl/fec32_synchk.sv | 41 ++++
 rtl/fec32_ctrl.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/fec32_pkg.sv
// Shared constants, state encoding and single-error syndrome table for the
// 2/3-rate FEC sequencer (shortened Hamming (15,10), g(D)=D^5+D^4+D^2+1).
package fec32_pkg;

   localparam int CW_LEN  = 15;
   localparam int DAT_LEN = 10;
   localparam int PAR_LEN = 5;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_CHK    = 2'd3
   } fec_state_t;

   // Entry k is D^(19-k) mod g(D): the syndrome left by a lone error in reception slot k.
   localparam logic [0:CW_LEN-1][PAR_LEN-1:0] SYN_TBL = {
      5'b10000, 5'b01000, 5'b00100, 5'b00010, 5'b00001,
      5'b11010, 5'b01101, 5'b11100, 5'b01110, 5'b00111,
      5'b11001, 5'b10110, 5'b01011, 5'b11111, 5'b10101
   };

   function automatic logic [DAT_LEN-1:0] flip_bit(input logic [DAT_LEN-1:0] data,
                                                   input logic [3:0]         pos);
      logic [DAT_LEN-1:0] res;
      res      = data;
      res[pos] = ~data[pos];
      return res;
   endfunction

endpackage

// File: rtl/fec32_synchk.sv
// Syndrome decoder: maps the captured syndrome to an error position and the
// corrected / uncorrectable flags.
module fec32_synchk
   import fec32_pkg::*;
(
   input  logic [PAR_LEN-1:0] syn,
   output logic [3:0]         pos,
   output logic               corr,
   output logic               uncorr
);

   // Table lookup of the syndrome; unmatched non-zero values are uncorrectable.
   always_comb begin
      pos    = 4'd0;
      corr   = 1'b1;
      uncorr = 1'b0;
      case (syn)
         5'b00000:    corr = 1'b0;
         SYN_TBL[0]:  pos  = 4'd0;
         SYN_TBL[1]:  pos  = 4'd1;
         SYN_TBL[2]:  pos  = 4'd2;
         SYN_TBL[3]:  pos  = 4'd3;
         SYN_TBL[4]:  pos  = 4'd4;
         SYN_TBL[5]:  pos  = 4'd5;
         SYN_TBL[6]:  pos  = 4'd6;
         SYN_TBL[7]:  pos  = 4'd7;
         SYN_TBL[8]:  pos  = 4'd8;
         SYN_TBL[9]:  pos  = 4'd9;
         SYN_TBL[10]: pos  = 4'd10;
         SYN_TBL[11]: pos  = 4'd11;
         SYN_TBL[12]: pos  = 4'd12;
         SYN_TBL[13]: pos  = 4'd13;
         SYN_TBL[14]: pos  = 4'd14;
         default: begin
            corr   = 1'b0;
            uncorr = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/fec32_ctrl.sv
// Per-codeword sequencer for the fec32 remainder/syndrome datapath: TX appends
// 5 parity bits to 10 data bits, RX corrects single errors from the syndrome.
module fec32_ctrl
   import fec32_pkg::*;
#(
   parameter int NBLK_W = 9
) (
   input  logic               clk_6M,
   input  logic               rstz,
   input  logic               start_p,
   input  logic               abort_p,
   input  logic               mode,
   input  logic [NBLK_W-1:0]  nblk,
   input  logic               bit_valid,
   input  logic               din,
   output logic               din_req,
   output logic               dout,
   output logic [DAT_LEN-1:0] rx_data,
   output logic               rx_valid,
   output logic               err_corr,
   output logic               err_uncorr,
   output logic               done_p,
   output logic               busy,
   output logic               fec32_loadini_p,
   output logic               fec32_shift_in,
   output logic               fec32_shift_out,
   output logic               fec32_datvalid_p,
   output logic               fec32_datin,
   input  logic [PAR_LEN-1:0] fec32_rem,
   input  logic [PAR_LEN-1:0] fec32_syn
);

   localparam logic [NBLK_W-1:0] ONE_BLK  = NBLK_W'(1'b1);
   localparam logic [NBLK_W-1:0] ZERO_BLK = {NBLK_W{1'b0}};

   fec_state_t         state_r;
   logic               mode_r;
   logic [NBLK_W-1:0]  blk_r;
   logic [3:0]         bcnt_r;
   logic [DAT_LEN-1:0] dbuf_r;
   logic [DAT_LEN-1:0] hold_r;

   logic               last_s;
   logic               bit_s;
   logic               chk_next_s;
   logic [3:0]         syn_pos_s;
   logic               syn_corr_s;
   logic               syn_uncorr_s;
   logic [DAT_LEN-1:0] fix_s;
   logic               rem_unused_s;

   fec32_synchk u_synchk (
      .syn    (fec32_syn),
      .pos    (syn_pos_s),
      .corr   (syn_corr_s),
      .uncorr (syn_uncorr_s)
   );

   assign rem_unused_s = ^fec32_rem[PAR_LEN-2:0];
   assign last_s       = (blk_r == ONE_BLK);
   assign bit_s        = bit_valid & ~abort_p;
   // A strobe landing in CHK already belongs to the next codeword.
   assign chk_next_s   = (state_r == ST_CHK) & ~last_s;

   assign fec32_datin      = din;
   assign fec32_datvalid_p = bit_s & ((state_r == ST_DATA) | (state_r == ST_PARITY) | chk_next_s);
   assign fec32_shift_in   = ~abort_p & ((state_r == ST_DATA) | chk_next_s);
   assign fec32_shift_out  = ~abort_p & (state_r == ST_PARITY);
   assign fec32_loadini_p  = abort_p | ((state_r == ST_IDLE) & start_p) |
                             (mode_r & (state_r == ST_DATA) & (bcnt_r == 4'd14) & bit_s);
   assign din_req          = ~mode_r & (state_r == ST_DATA);
   assign busy             = (state_r != ST_IDLE);

   // TX bit path: data passes straight through, parity comes from the remainder MSB.
   always_comb begin
      case (state_r)
         ST_DATA:   dout = ~mode_r & din;
         ST_PARITY: dout = fec32_rem[PAR_LEN-1];
         default:   dout = 1'b0;
      endcase
   end

   // Apply the single-bit correction only when the error sits in the data part.
   always_comb begin
      if (syn_corr_s && (syn_pos_s < 4'd10)) begin
         fix_s = flip_bit(hold_r, syn_pos_s);
      end else begin
         fix_s = hold_r;
      end
   end

   // Sequencer FSM with bit/block counters and registered RX results.
   always_ff @(posedge clk_6M or negedge rstz) begin
      if (!rstz) begin
         state_r    <= ST_IDLE;
         mode_r     <= 1'b0;
         blk_r      <= ZERO_BLK;
         bcnt_r     <= 4'd0;
         dbuf_r     <= {DAT_LEN{1'b0}};
         hold_r     <= {DAT_LEN{1'b0}};
         rx_data    <= {DAT_LEN{1'b0}};
         rx_valid   <= 1'b0;
         err_corr   <= 1'b0;
         err_uncorr <= 1'b0;
         done_p     <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         done_p   <= 1'b0;
         if (abort_p) begin
            state_r <= ST_IDLE;
            bcnt_r  <= 4'd0;
         end else begin
            case (state_r)
               ST_IDLE: begin
                  if (start_p) begin
                     mode_r  <= mode;
                     blk_r   <= (nblk == ZERO_BLK) ? ONE_BLK : nblk;
                     bcnt_r  <= 4'd0;
                     dbuf_r  <= {DAT_LEN{1'b0}};
                     state_r <= ST_DATA;
                  end
               end
               ST_DATA: begin
                  if (bit_s) begin
                     if (mode_r) begin
                        if (bcnt_r < 4'd10) begin
                           dbuf_r[bcnt_r] <= din;
                        end
                        if (bcnt_r == 4'd14) begin
                           hold_r  <= dbuf_r;
                           bcnt_r  <= 4'd0;
                           state_r <= ST_CHK;
                        end else begin
                           bcnt_r <= bcnt_r + 4'd1;
                        end
                     end else begin
                        bcnt_r <= bcnt_r + 4'd1;
                        if (bcnt_r == 4'd9) begin
                           state_r <= ST_PARITY;
                        end
                     end
                  end
               end
               ST_PARITY: begin
                  if (bit_s) begin
                     if (bcnt_r == 4'd14) begin
                        bcnt_r <= 4'd0;
                        if (last_s) begin
                           done_p  <= 1'b1;
                           state_r <= ST_IDLE;
                        end else begin
                           blk_r   <= blk_r - ONE_BLK;
                           state_r <= ST_DATA;
                        end
                     end else begin
                        bcnt_r <= bcnt_r + 4'd1;
                     end
                  end
               end
               ST_CHK: begin
                  rx_data    <= fix_s;
                  err_corr   <= syn_corr_s;
                  err_uncorr <= syn_uncorr_s;
                  rx_valid   <= 1'b1;
                  if (last_s) begin
                     done_p  <= 1'b1;
                     state_r <= ST_IDLE;
                  end else begin
                     blk_r   <= blk_r - ONE_BLK;
                     state_r <= ST_DATA;
                     if (bit_s) begin
                        dbuf_r[0] <= din;
                        bcnt_r    <= 4'd1;
                     end
                  end
               end
               default: state_r <= ST_IDLE;
            endcase
         end
      end
   end

endmodule
